reg_write_sequencer: RTL and testbench

Command-side driver for the team's 16-bit FunSel-controlled register. It accepts word-level commands (load, increment/decrement by N, clear) over a valid/ready handshake and drives the register's `E`/`FunSel`/`I` pins cycle by cycle. Full 16-bit loads are split into a write-low and a write-high step. The block keeps a shadow copy of the value the register must hold, which the bench and upstream logic use as the expected value.

---
 rtl/reg_write_sequencer.sv | 171 +++++++++++++++++
 tb/tb_reg_write_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_sequencer.sv
// Command sequencer for the 16-bit FunSel register: turns load/inc/dec/clear commands into
// per-cycle E/FunSel/I drives and tracks a shadow copy. Optional feature: SIGNEXT_LOAD_EN.
module reg_write_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [1:0]       CmdOp,
    input  logic [WIDTH-1:0] CmdData,
    input  logic [3:0]       CmdCount,
    output logic             E,
    output logic [2:0]       FunSel,
    output logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Shadow,
    output logic             Done
);

    localparam int unsigned Half = WIDTH / 2;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWlow  = 2'd1;
    localparam logic [1:0] StWhigh = 2'd2;
    localparam logic [1:0] StStep  = 2'd3;

    localparam logic [1:0] OpLoad = 2'b00;
    localparam logic [1:0] OpInc  = 2'b01;
    localparam logic [1:0] OpDec  = 2'b10;
    localparam logic [1:0] OpClr  = 2'b11;

    localparam logic [2:0] FsDec    = 3'b000;
    localparam logic [2:0] FsInc    = 3'b001;
    localparam logic [2:0] FsHold   = 3'b010;
    localparam logic [2:0] FsClr    = 3'b011;
    localparam logic [2:0] FsLoadLo = 3'b100;
    localparam logic [2:0] FsLoadHi = 3'b110;
    localparam logic [2:0] FsLoadSx = 3'b111;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             sext_q, sext_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             e_q, e_d;
    logic [2:0]       funsel_q, funsel_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic             done_q, done_d;
    logic             sext_fits;

`ifdef SIGNEXT_LOAD_EN
    // Upper half is a pure sign extension of the lower half: one-cycle load suffices.
    assign sext_fits = (CmdData[WIDTH-1:Half] == {Half{CmdData[Half-1]}});
`else
    assign sext_fits = 1'b0;
`endif

    assign CmdReady = (state_q == StIdle);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        sext_d   = sext_q;
        shadow_d = shadow_q;

        case (state_q)
            StIdle: begin
                if (CmdValid) begin
                    op_d    = CmdOp;
                    data_d  = CmdData;
                    cnt_d   = (CmdOp == OpClr) ? 4'd0 : CmdCount;
                    sext_d  = (CmdOp == OpLoad) && sext_fits;
                    state_d = (CmdOp == OpLoad) ? StWlow : StStep;
                end
            end
            StWlow: begin
                if (sext_q) begin
                    shadow_d = data_q;
                    state_d  = StIdle;
                end else begin
                    shadow_d = {{Half{1'b0}}, data_q[Half-1:0]};
                    state_d  = StWhigh;
                end
            end
            StWhigh: begin
                shadow_d = {data_q[WIDTH-1:Half], shadow_q[Half-1:0]};
                state_d  = StIdle;
            end
            StStep: begin
                unique case (op_q)
                    OpInc:   shadow_d = shadow_q + One;
                    OpDec:   shadow_d = shadow_q - One;
                    default: shadow_d = '0;
                endcase
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin drives are registered, so decode them from the state being entered.
    always_comb begin
        e_d      = 1'b0;
        funsel_d = FsHold;
        i_d      = '0;
        case (state_d)
            StWlow: begin
                e_d      = 1'b1;
                funsel_d = sext_d ? FsLoadSx : FsLoadLo;
                i_d      = {{Half{1'b0}}, data_d[Half-1:0]};
            end
            StWhigh: begin
                e_d      = 1'b1;
                funsel_d = FsLoadHi;
                i_d      = data_d;
            end
            StStep: begin
                e_d = 1'b1;
                unique case (op_d)
                    OpInc:   funsel_d = FsInc;
                    OpDec:   funsel_d = FsDec;
                    default: funsel_d = FsClr;
                endcase
            end
            default: ;
        endcase
        done_d = (state_q != StIdle) && (state_d == StIdle);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StIdle;
            op_q     <= OpLoad;
            data_q   <= '0;
            cnt_q    <= 4'd0;
            sext_q   <= 1'b0;
            shadow_q <= '0;
            e_q      <= 1'b0;
            funsel_q <= FsHold;
            i_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            sext_q   <= sext_d;
            shadow_q <= shadow_d;
            e_q      <= e_d;
            funsel_q <= funsel_d;
            i_q      <= i_d;
            done_q   <= done_d;
        end
    end

    assign E      = e_q;
    assign FunSel = funsel_q;
    assign I      = i_q;
    assign Shadow = shadow_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Scoreboard bench for reg_write_sequencer: a command-level model queues the expected
// per-cycle drives; a negedge monitor pops and compares whenever E is asserted.
module tb_reg_write_sequencer;

    localparam int W = 16;

    logic         Clock;
    logic         Reset;
    logic         CmdValid;
    logic         CmdReady;
    logic [1:0]   CmdOp;
    logic [W-1:0] CmdData;
    logic [3:0]   CmdCount;
    logic         E;
    logic [2:0]   FunSel;
    logic [W-1:0] I;
    logic [W-1:0] Shadow;
    logic         Done;

    reg_write_sequencer #(.WIDTH(W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .CmdValid (CmdValid),
        .CmdReady (CmdReady),
        .CmdOp    (CmdOp),
        .CmdData  (CmdData),
        .CmdCount (CmdCount),
        .E        (E),
        .FunSel   (FunSel),
        .I        (I),
        .Shadow   (Shadow),
        .Done     (Done)
    );

    typedef struct {
        logic [2:0]   fs;
        logic [W-1:0] i;
        logic [W-1:0] sh;
        bit           last;
    } exp_t;

    exp_t         expq[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           busy = 0;
    int           cmds = 0;
    int           dones = 0;
    bit           mon_en = 0;
    logic [W-1:0] model_sh = '0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void push(input logic [2:0] fs, input logic [W-1:0] i,
                                 input logic [W-1:0] sh, input bit last);
        exp_t e;
        e.fs = fs;
        e.i = i;
        e.sh = sh;
        e.last = last;
        expq.push_back(e);
    endfunction

    // Command-level reference: what the register pins must see, one entry per driven cycle.
    task automatic model_cmd(input logic [1:0] op, input logic [W-1:0] d, input logic [3:0] c);
        bit sx;
        sx = 1'b0;
        cmds++;
        case (op)
            2'b00: begin
`ifdef SIGNEXT_LOAD_EN
                sx = (d[15:8] == {8{d[7]}});
`endif
                if (sx) begin
                    push(3'b111, {8'h00, d[7:0]}, d, 1'b1);
                    busy = 1;
                end else begin
                    push(3'b100, {8'h00, d[7:0]}, {8'h00, d[7:0]}, 1'b0);
                    push(3'b110, d, d, 1'b1);
                    busy = 2;
                end
                model_sh = d;
            end
            2'b01: begin
                for (int j = 0; j <= int'(c); j++) begin
                    model_sh = model_sh + 16'd1;
                    push(3'b001, '0, model_sh, j == int'(c));
                end
                busy = int'(c) + 1;
            end
            2'b10: begin
                for (int j = 0; j <= int'(c); j++) begin
                    model_sh = model_sh - 16'd1;
                    push(3'b000, '0, model_sh, j == int'(c));
                end
                busy = int'(c) + 1;
            end
            default: begin
                model_sh = '0;
                push(3'b011, '0, '0, 1'b1);
                busy = 1;
            end
        endcase
    endtask

    // Called at a negedge; holds CmdValid with junk while busy, then presents the command.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] d, input logic [3:0] c);
        while (busy > 0) begin
            CmdValid = 1'b1;
            CmdOp    = 2'($urandom);
            CmdData  = W'($urandom);
            CmdCount = 4'($urandom);
            chk("ready_while_busy", CmdReady, 0);
            @(negedge Clock);
            busy--;
        end
        CmdValid = 1'b1;
        CmdOp    = op;
        CmdData  = d;
        CmdCount = c;
        chk("ready_when_idle", CmdReady, 1);
        model_cmd(op, d, c);
        @(negedge Clock);
    endtask

    task automatic gap();
        CmdValid = 1'b0;
        @(negedge Clock);
        if (busy > 0) busy--;
    endtask

    task automatic wait_idle();
        while (busy > 0) gap();
        CmdValid = 1'b0;
    endtask

    // Monitor: compares pin drives, shadow one cycle later, and the Done pulse.
    initial begin
        exp_t         e;
        bit           pend_sh;
        bit           pend_done;
        logic [W-1:0] exp_sh;
        pend_sh = 0;
        pend_done = 0;
        exp_sh = '0;
        forever begin
            @(negedge Clock);
            if (!mon_en) begin
                pend_sh = 0;
                pend_done = 0;
            end else begin
                if (pend_sh) chk("shadow", Shadow, exp_sh);
                chk("done", Done, pend_done);
                if (Done) dones++;
                pend_sh = 0;
                pend_done = 0;
                if (E) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_E", E, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("funsel", FunSel, e.fs);
                        chk("i", I, e.i);
                        pend_sh = 1;
                        exp_sh = e.sh;
                        pend_done = e.last;
                    end
                end else begin
                    chk("idle_funsel", FunSel, 3'b010);
                    chk("idle_i", I, 0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        Reset    = 1'b0;
        CmdValid = 1'b0;
        CmdOp    = 2'b00;
        CmdData  = '0;
        CmdCount = 4'd0;
        #12;
        chk("rst_E", E, 0);
        chk("rst_FunSel", FunSel, 3'b010);
        chk("rst_I", I, 0);
        chk("rst_Shadow", Shadow, 0);
        chk("rst_Done", Done, 0);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        chk("ready_after_reset", CmdReady, 1);
        mon_en = 1;
        @(negedge Clock);

        issue(2'b00, 16'hA55A, 4'd0);
        issue(2'b00, 16'hFFFE, 4'd0);
        issue(2'b01, 16'h0000, 4'd2);
        issue(2'b11, 16'h0000, 4'd0);
        issue(2'b10, 16'h0000, 4'd0);
        issue(2'b00, 16'hFF80, 4'd0);
        issue(2'b00, 16'h0180, 4'd0);
        wait_idle();
        gap();

        repeat (300) begin
            if ($urandom_range(0, 3) == 0) gap();
            case ($urandom_range(0, 3))
                0:       d = 16'hFFFF;
                1:       d = 16'h0000;
                2:       d = {{8{1'($urandom)}}, 1'($urandom), 7'($urandom)};
                default: d = 16'($urandom);
            endcase
            if (d[15:8] == {8{~d[7]}} && $urandom_range(0, 1) == 1) d[7] = ~d[7];
            issue(2'($urandom_range(0, 3)), d, 4'($urandom_range(0, 15)));
        end
        wait_idle();
        @(negedge Clock);
        @(negedge Clock);
        chk("queue_empty", expq.size(), 0);
        chk("done_count", dones, cmds);

        // Reset while the high byte is being written.
        issue(2'b00, 16'h1234, 4'd0);
        @(posedge Clock);
        #2;
        mon_en = 0;
        Reset = 1'b0;
        #1;
        chk("midrst_E", E, 0);
        chk("midrst_FunSel", FunSel, 3'b010);
        chk("midrst_Shadow", Shadow, 0);
        chk("midrst_Done", Done, 0);
        @(negedge Clock);
        Reset = 1'b1;
        expq.delete();
        busy = 0;
        model_sh = '0;
        CmdValid = 1'b0;
        chk("midrst_ready", CmdReady, 1);
        #1;
        mon_en = 1;
        @(negedge Clock);
        issue(2'b11, 16'h0000, 4'd0);
        issue(2'b10, 16'h0000, 4'd0);
        wait_idle();
        @(negedge Clock);
        @(negedge Clock);
        chk("final_shadow", Shadow, 16'hFFFF);
        chk("final_queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
